// File: rtl/fixed_enc_pkg.sv
// ---------------------------------------------------------------------------
// fixed_enc_pkg
// Shared definitions for the fixed-order encoder block sequencer.
//   state_t          : sequencer states, in the order a block walks through them
//   ORDER_W          : width of a predictor order / chooser result
//   NUM_ORDERS       : number of fixed-order encoders in the bank (orders 0..4)
//   DEFAULT_SAMPLE_W : default audio sample width
// ---------------------------------------------------------------------------
package fixed_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    CAPTURE,
    HOLD
  } state_t;

  localparam int ORDER_W          = 3;
  localparam int NUM_ORDERS       = 5;
  localparam int DEFAULT_SAMPLE_W = 16;

endpackage

// File: rtl/fixed_block_counter.sv
// ---------------------------------------------------------------------------
// fixed_block_counter
// Count-to-limit counter with clear, increment and a done flag. The count
// saturates at LIMIT, so it never wraps within one block.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   clear_i : synchronous clear to zero (wins over incr_i)
//   incr_i  : advance the count by one
//   done_o  : high in the cycle whose increment brings the count to LIMIT
// ---------------------------------------------------------------------------
module fixed_block_counter
  import fixed_enc_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic incr_i,
  output logic done_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear first, otherwise step towards LIMIT and stop there.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i && (count_q != WIDTH'(LIMIT))) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // done looks one step ahead so the caller can change state on the very
  // edge that performs the final increment.
  assign done_o = incr_i && (count_q == WIDTH'(LIMIT - 1));

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fixed_block_sequencer.sv
// ---------------------------------------------------------------------------
// fixed_block_sequencer
// Sequences the fixed-order encoder bank and best-order chooser over blocks
// of BLOCK_SIZE samples: clear the bank, feed the block, flush the pipeline,
// capture the winning order and hold it until the consumer takes it.
//   iClock       : clock, rising edge
//   iReset       : synchronous active-low reset
//   iEnable      : run enable (pauses sample acceptance while feeding)
//   iSampleValid : upstream sample valid
//   iSample      : upstream signed sample
//   oSampleReady : sample accepted when iSampleValid && oSampleReady
//   oEncEnable   : enable to the encoders and chooser
//   oEncReset    : active-high clear to the encoders and chooser
//   oEncFlush    : pipeline flush marker, the chooser must not accumulate
//   oEncSample   : sample presented to the encoder bank
//   iBest        : chooser result
//   oBestValid   : block result valid
//   oBest        : captured best order
//   oBlockIndex  : index of the block the result belongs to (wraps)
//   iBestReady   : consumer takes the result
//   oBusy        : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module fixed_block_sequencer
  import fixed_enc_pkg::*;
#(
  parameter int SAMPLE_W     = DEFAULT_SAMPLE_W,
  parameter int BLOCK_SIZE   = 4096,
  parameter int CNT_W        = 12,
  parameter int PIPE_LATENCY = 8
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iEnable,
  input  logic                       iSampleValid,
  input  logic signed [SAMPLE_W-1:0] iSample,
  output logic                       oSampleReady,
  output logic                       oEncEnable,
  output logic                       oEncReset,
  output logic                       oEncFlush,
  output logic signed [SAMPLE_W-1:0] oEncSample,
  input  logic [ORDER_W-1:0]         iBest,
  output logic                       oBestValid,
  output logic [ORDER_W-1:0]         oBest,
  output logic [15:0]                oBlockIndex,
  input  logic                       iBestReady,
  output logic                       oBusy
);

  // One spare bit so the sample count can actually reach BLOCK_SIZE.
  localparam int SAMPLE_CNT_W = CNT_W + 1;
  localparam int FLUSH_CNT_W  = $clog2(PIPE_LATENCY + 1);

  state_t                       state_q, state_d;
  logic                         enc_en_q, enc_en_d;
  logic                         enc_reset_q, enc_reset_d;
  logic                         enc_flush_q, enc_flush_d;
  logic signed [SAMPLE_W-1:0]   enc_sample_q, enc_sample_d;
  logic                         best_valid_q, best_valid_d;
  logic [ORDER_W-1:0]           best_q, best_d;
  logic [15:0]                  block_idx_q, block_idx_d;

  logic sample_ready;
  logic transfer;
  logic sample_done;
  logic flush_done;

  // Ready must follow iEnable within the same cycle, so it is the one output
  // decoded directly from the state register rather than pipelined.
  assign sample_ready = (state_q == FEED) && iEnable;
  assign transfer     = sample_ready && iSampleValid;

  fixed_block_counter #(
    .WIDTH (SAMPLE_CNT_W),
    .LIMIT (BLOCK_SIZE)
  ) u_sample_counter (
    .clk     (iClock),
    .rst_n   (iReset),
    .clear_i (state_q == CLEAR),
    .incr_i  (transfer),
    .done_o  (sample_done)
  );

  // Held clear outside FLUSH, so every flush starts counting from zero.
  fixed_block_counter #(
    .WIDTH (FLUSH_CNT_W),
    .LIMIT (PIPE_LATENCY)
  ) u_flush_counter (
    .clk     (iClock),
    .rst_n   (iReset),
    .clear_i (state_q != FLUSH),
    .incr_i  (state_q == FLUSH),
    .done_o  (flush_done)
  );

  // Next-state and next-output decode. The encoder-side outputs are
  // registered, so enable, sample, reset and flush all reach the bank one
  // cycle after the decision and stay aligned with each other; the last
  // sample enable therefore never overlaps the first flush cycle.
  always_comb begin
    state_d      = state_q;
    enc_en_d     = 1'b0;
    enc_reset_d  = 1'b0;
    enc_flush_d  = 1'b0;
    enc_sample_d = enc_sample_q;
    best_valid_d = best_valid_q;
    best_d       = best_q;
    block_idx_d  = block_idx_q;

    case (state_q)
      IDLE: begin
        if (iEnable) begin
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        enc_reset_d = 1'b1;
        state_d     = FEED;
      end

      FEED: begin
        if (transfer) begin
          enc_en_d     = 1'b1;
          enc_sample_d = iSample;
          if (sample_done) begin
            state_d = FLUSH;
          end
        end
      end

      FLUSH: begin
        enc_en_d     = 1'b1;
        enc_flush_d  = 1'b1;
        enc_sample_d = '0;
        if (flush_done) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        best_d       = iBest;
        best_valid_d = 1'b1;
        state_d      = HOLD;
      end

      HOLD: begin
        if (iBestReady) begin
          best_valid_d = 1'b0;
          block_idx_d  = block_idx_q + 16'd1;
          state_d      = iEnable ? CLEAR : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial block.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_q      <= IDLE;
      enc_en_q     <= 1'b0;
      enc_reset_q  <= 1'b0;
      enc_flush_q  <= 1'b0;
      enc_sample_q <= '0;
      best_valid_q <= 1'b0;
      best_q       <= '0;
      block_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      enc_en_q     <= enc_en_d;
      enc_reset_q  <= enc_reset_d;
      enc_flush_q  <= enc_flush_d;
      enc_sample_q <= enc_sample_d;
      best_valid_q <= best_valid_d;
      best_q       <= best_d;
      block_idx_q  <= block_idx_d;
    end
  end

  assign oSampleReady = sample_ready;
  assign oEncEnable   = enc_en_q;
  assign oEncReset    = enc_reset_q;
  assign oEncFlush    = enc_flush_q;
  assign oEncSample   = enc_sample_q;
  assign oBestValid   = best_valid_q;
  assign oBest        = best_q;
  assign oBlockIndex  = block_idx_q;
  assign oBusy        = (state_q != IDLE);

endmodule

// File: tb/tb_fixed_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fixed_block_sequencer
// Self-checking bench for fixed_block_sequencer with a small block size.
// Accepted samples and expected block results go into queues; a monitor
// pops and compares them as the encoder-side outputs and results appear.
// ---------------------------------------------------------------------------
module tb_fixed_block_sequencer;

  localparam int SAMPLE_W     = 16;
  localparam int BLOCK_SIZE   = 16;
  localparam int CNT_W        = 4;
  localparam int PIPE_LATENCY = 8;

  logic                iClock = 1'b0;
  logic                iReset = 1'b0;
  logic                iEnable = 1'b0;
  logic                iSampleValid = 1'b0;
  logic [SAMPLE_W-1:0] iSample = '0;
  logic                oSampleReady;
  logic                oEncEnable;
  logic                oEncReset;
  logic                oEncFlush;
  logic [SAMPLE_W-1:0] oEncSample;
  logic [2:0]          iBest = 3'd0;
  logic                oBestValid;
  logic [2:0]          oBest;
  logic [15:0]         oBlockIndex;
  logic                iBestReady = 1'b0;
  logic                oBusy;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int expIndex = 0;
  int bestRises = 0;
  int riseCycle = 0;
  int lastXfer = 0;
  int encEvents = 0;
  int flushRun = 0;
  int resetRun = 0;
  bit prevValid = 1'b0;

  logic [SAMPLE_W-1:0] sampleQ[$];
  logic [18:0]         resultQ[$];

  fixed_block_sequencer #(
    .SAMPLE_W     (SAMPLE_W),
    .BLOCK_SIZE   (BLOCK_SIZE),
    .CNT_W        (CNT_W),
    .PIPE_LATENCY (PIPE_LATENCY)
  ) dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .iEnable      (iEnable),
    .iSampleValid (iSampleValid),
    .iSample      (iSample),
    .oSampleReady (oSampleReady),
    .oEncEnable   (oEncEnable),
    .oEncReset    (oEncReset),
    .oEncFlush    (oEncFlush),
    .oEncSample   (oEncSample),
    .iBest        (iBest),
    .oBestValid   (oBestValid),
    .oBest        (oBest),
    .oBlockIndex  (oBlockIndex),
    .iBestReady   (iBestReady),
    .oBusy        (oBusy)
  );

  // Free-running clock and cycle counter.
  always #5 iClock = ~iClock;

  always @(posedge iClock) cycleCount <= cycleCount + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  // Monitor on the falling edge: encoder samples against the scoreboard,
  // flush and clear pulse widths, and block results on oBestValid rising.
  always @(negedge iClock) begin
    logic [18:0] expResult;
    if (oEncEnable === 1'b1 && oEncFlush === 1'b0) begin
      encEvents++;
      if (sampleQ.size() == 0) begin
        checkOutput("enc_unexpected", 32'd1, 32'd0);
      end else begin
        checkOutput("enc_sample", oEncSample, sampleQ.pop_front());
      end
    end
    if (oEncFlush === 1'b1) begin
      flushRun++;
      checkOutput("flush_sample", oEncSample, 32'd0);
      checkOutput("flush_enable", oEncEnable, 32'd1);
    end else if (flushRun != 0) begin
      checkOutput("flush_len", flushRun, PIPE_LATENCY);
      flushRun = 0;
    end
    if (oEncReset === 1'b1) begin
      resetRun++;
    end else if (resetRun != 0) begin
      checkOutput("enc_reset_len", resetRun, 32'd1);
      resetRun = 0;
    end
    if (oBestValid === 1'b1 && !prevValid) begin
      bestRises++;
      riseCycle = cycleCount;
      if (resultQ.size() == 0) begin
        checkOutput("result_unexpected", 32'd1, 32'd0);
      end else begin
        expResult = resultQ.pop_front();
        checkOutput("best", oBest, expResult[18:16]);
        checkOutput("block_index", oBlockIndex, expResult[15:0]);
      end
    end
    prevValid = (oBestValid === 1'b1);
  end

  // Drives one block. pattern 0 = valid always high, 1 = valid 1,0,0,...
  // A pause drops iEnable for pauseLen cycles once pauseAt samples are in.
  // Returns just after the first edge following the result becoming valid.
  task automatic applyStimulus(input int pattern, input logic [2:0] best,
                               input int pauseAt, input int pauseLen);
    int  accepted    = 0;
    int  budget      = 0;
    int  phase       = 0;
    bit  paused      = 1'b0;
    int  risesBefore = bestRises;
    int  encBefore   = encEvents;
    iBest = best;
    resultQ.push_back({best, 16'(expIndex)});
    while (accepted < BLOCK_SIZE && budget < 400) begin
      iSampleValid = (pattern == 0) ? 1'b1 : (phase % 3 == 0);
      iSample      = SAMPLE_W'($urandom);
      phase++;
      @(negedge iClock);
      if (iSampleValid && oSampleReady) begin
        sampleQ.push_back(iSample);
        accepted++;
        lastXfer = cycleCount;
      end
      tick();
      budget++;
      if (accepted == pauseAt && !paused) begin
        paused       = 1'b1;
        iEnable      = 1'b0;
        iSampleValid = 1'b1;
        repeat (pauseLen) begin
          @(negedge iClock);
          checkOutput("pause_ready", oSampleReady, 32'd0);
          tick();
        end
        iEnable = 1'b1;
      end
    end
    iSampleValid = 1'b0;
    checkOutput("xfer_count", accepted, BLOCK_SIZE);
    checkOutput("ready_after_last", oSampleReady, 32'd0);
    budget = 0;
    while (bestRises == risesBefore && budget < 60) begin
      tick();
      budget++;
    end
    if (bestRises == risesBefore) begin
      checkOutput("result_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("result_latency", riseCycle - lastXfer, PIPE_LATENCY + 2);
      checkOutput("enc_pulses", encEvents - encBefore, BLOCK_SIZE);
    end
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    int acc;
    int budget;

    // Reset state.
    repeat (3) tick();
    checkOutput("rst_ready", oSampleReady, 32'd0);
    checkOutput("rst_enc_en", oEncEnable, 32'd0);
    checkOutput("rst_enc_reset", oEncReset, 32'd0);
    checkOutput("rst_flush", oEncFlush, 32'd0);
    checkOutput("rst_enc_sample", oEncSample, 32'd0);
    checkOutput("rst_best_valid", oBestValid, 32'd0);
    checkOutput("rst_best", oBest, 32'd0);
    checkOutput("rst_index", oBlockIndex, 32'd0);
    checkOutput("rst_busy", oBusy, 32'd0);

    // Start a block, then reset after 5 samples: partial block discarded.
    iReset       = 1'b1;
    iEnable      = 1'b1;
    iSampleValid = 1'b1;
    acc          = 0;
    budget       = 0;
    while (acc < 5 && budget < 50) begin
      iSample = SAMPLE_W'($urandom);
      @(negedge iClock);
      if (iSampleValid && oSampleReady) begin
        sampleQ.push_back(iSample);
        acc++;
      end
      tick();
      budget++;
    end
    checkOutput("pre_reset_xfers", acc, 32'd5);
    iSampleValid = 1'b0;
    iReset       = 1'b0;
    tick();
    checkOutput("midrst_busy", oBusy, 32'd0);
    checkOutput("midrst_ready", oSampleReady, 32'd0);
    checkOutput("midrst_enc_en", oEncEnable, 32'd0);
    checkOutput("midrst_enc_sample", oEncSample, 32'd0);
    checkOutput("midrst_queue", sampleQ.size(), 32'd0);
    iReset  = 1'b1;
    iEnable = 1'b0;
    repeat (20) tick();
    checkOutput("midrst_no_result", bestRises, 32'd0);
    checkOutput("midrst_index", oBlockIndex, 32'd0);
    checkOutput("midrst_idle", oBusy, 32'd0);

    // Block A: continuous stream, result held under backpressure.
    iEnable    = 1'b1;
    iBestReady = 1'b0;
    applyStimulus(0, 3'd3, -1, 0);
    repeat (20) begin
      checkOutput("hold_valid", oBestValid, 32'd1);
      checkOutput("hold_best", oBest, 32'd3);
      checkOutput("hold_ready", oSampleReady, 32'd0);
      checkOutput("hold_busy", oBusy, 32'd1);
      tick();
    end
    iBestReady = 1'b1;
    tick();
    expIndex++;
    checkOutput("consume_valid", oBestValid, 32'd0);
    checkOutput("consume_ready_clear", oSampleReady, 32'd0);
    checkOutput("consume_index", oBlockIndex, 32'd1);
    tick();
    checkOutput("ready_return", oSampleReady, 32'd1);

    // Block B: stalled upstream, out-of-range order passes through,
    // consumer already ready so the result is taken after one cycle.
    applyStimulus(1, 3'd5, -1, 0);
    expIndex++;
    checkOutput("b_auto_consumed", oBestValid, 32'd0);
    checkOutput("b_busy", oBusy, 32'd1);

    // Block C: enable dropped at sample 7, then stop at the result.
    iBestReady = 1'b0;
    applyStimulus(0, 3'd0, 7, 6);
    checkOutput("c_valid_held", oBestValid, 32'd1);
    iEnable    = 1'b0;
    iBestReady = 1'b1;
    tick();
    expIndex++;
    checkOutput("c_consumed", oBestValid, 32'd0);
    checkOutput("c_idle_busy", oBusy, 32'd0);
    checkOutput("c_index", oBlockIndex, 32'(expIndex));
    repeat (5) tick();
    checkOutput("c_stay_idle", oBusy, 32'd0);
    checkOutput("c_idle_ready", oSampleReady, 32'd0);
    checkOutput("total_results", bestRises, 32'd3);
    checkOutput("results_drained", resultQ.size(), 32'd0);
    checkOutput("samples_drained", sampleQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
